// File: rtl/cdc_arb_pkg.sv
// Shared definitions for cdc_token_arbiter: parameter defaults, FSM state
// encoding and the round-robin pick helper used by rr_pick_arbiter.
package cdc_arb_pkg;

   localparam int N_REQ_DEF = 4;
   localparam int CNT_W_DEF = 4;
   localparam int ID_W_DEF  = 2;
   localparam int MAX_REQ   = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ARB   = 2'b01,
      STALL = 2'b10
   } arb_state_e;

   typedef struct packed {
      logic       valid;
      logic [2:0] idx;
   } pick_t;

   // Rotate so rr sits at bit 0, take the lowest set bit, then rotate the
   // winning position back into an absolute requester index (mod n).
   function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] eligible,
                                     input logic [2:0]         rr,
                                     input logic [3:0]         n);
      pick_t              res;
      logic [MAX_REQ-1:0] rot;
      logic [3:0]         pos;
      logic               found;
      res   = '0;
      rot   = '0;
      found = 1'b0;
      for (int k = 0; k < MAX_REQ; k++) begin
         pos = {1'b0, rr} + 4'(k);
         if (pos >= n) pos = pos - n;
         if (4'(k) < n) rot[k] = eligible[pos[2:0]];
      end
      for (int k = 0; k < MAX_REQ; k++) begin
         if (rot[k] && !found) begin
            found = 1'b1;
            pos   = {1'b0, rr} + 4'(k);
            if (pos >= n) pos = pos - n;
            res.idx = pos[2:0];
         end
      end
      res.valid = found;
      return res;
   endfunction

endpackage

// File: rtl/rr_pick_arbiter.sv
// Combinational round-robin selector: first eligible requester at or after rr,
// wrapping modulo N_REQ.
module rr_pick_arbiter
   import cdc_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int ID_W  = ID_W_DEF
) (
   input  logic [N_REQ-1:0] eligible,
   input  logic [ID_W-1:0]  rr,
   output logic             valid,
   output logic [ID_W-1:0]  idx
);

   pick_t pick;

   always_comb begin
      pick  = rr_pick(MAX_REQ'(eligible), 3'(rr), 4'(N_REQ));
      valid = pick.valid;
      idx   = ID_W'(pick.idx);
   end

endmodule

// File: rtl/cdc_token_arbiter.sv
// Round-robin drain of per-requester event counters into one clk_domain_cross
// token channel. Optional sticky overflow flags: define CDC_ARB_OVF_EN.
module cdc_token_arbiter
   import cdc_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int CNT_W = CNT_W_DEF,
   parameter int ID_W  = ID_W_DEF
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [N_REQ-1:0] req,
   input  logic             full,
   output logic             issue,
   output logic [ID_W-1:0]  issue_id,
   output logic [N_REQ-1:0] ack,
   output logic [N_REQ-1:0] pending
`ifdef CDC_ARB_OVF_EN
   ,
   output logic [N_REQ-1:0] ovf,
   input  logic             ovf_clr
`endif
);

   logic [CNT_W-1:0] cnt [N_REQ];
   logic [N_REQ-1:0] eligible;
   logic [N_REQ-1:0] served;
   logic [ID_W-1:0]  rr;
   logic [ID_W-1:0]  pick_idx;
   logic             pick_valid;
   logic             grant_en;
   arb_state_e       state_q;
   arb_state_e       state_d;

   always_comb begin
      for (int i = 0; i < N_REQ; i++) eligible[i] = (cnt[i] != '0);
   end

   assign pending = eligible;

   rr_pick_arbiter #(
      .N_REQ(N_REQ),
      .ID_W (ID_W)
   ) u_pick (
      .eligible(eligible),
      .rr      (rr),
      .valid   (pick_valid),
      .idx     (pick_idx)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = IDLE;
      grant_en = 1'b0;
      served   = '0;
      if (|eligible) begin
         if (full) begin
            state_d = STALL;
         end else begin
            state_d          = ARB;
            grant_en         = pick_valid;
            served[pick_idx] = pick_valid;
         end
      end
   end

   // The registered state is ARB exactly when a token was granted last cycle.
   assign issue = (state_q == ARB);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         issue_id <= '0;
         ack      <= '0;
         rr       <= '0;
      end else begin
         issue_id <= grant_en ? pick_idx : '0;
         ack      <= served;
         if (grant_en) rr <= (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end
   end

   // A request coinciding with its own grant cancels out; saturated requests drop.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            case ({req[i], served[i]})
               2'b10:   if (cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
               2'b01:   cnt[i] <= cnt[i] - 1'b1;
               default: cnt[i] <= cnt[i];
            endcase
         end
      end
   end

`ifdef CDC_ARB_OVF_EN
   logic [N_REQ-1:0] dropped;

   always_comb begin
      for (int i = 0; i < N_REQ; i++) dropped[i] = req[i] & ~served[i] & (cnt[i] == '1);
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) ovf <= '0;
      else     ovf <= (ovf & {N_REQ{~ovf_clr}}) | dropped;
   end
`endif

endmodule

// File: tb/tb_cdc_token_arbiter.sv
// Directed scenario bench for cdc_token_arbiter at default parameters.
// Overflow checks are included when CDC_ARB_OVF_EN is defined.
module tb_cdc_token_arbiter;

   logic       clk = 1'b0;
   logic       clr;
   logic [3:0] req;
   logic       full;
   logic       issue;
   logic [1:0] issue_id;
   logic [3:0] ack;
   logic [3:0] pending;
`ifdef CDC_ARB_OVF_EN
   logic [3:0] ovf;
   logic       ovf_clr;
`endif

   int compared   = 0;
   int mismatched = 0;

   cdc_token_arbiter dut (
      .clk     (clk),
      .clr     (clr),
      .req     (req),
      .full    (full),
      .issue   (issue),
      .issue_id(issue_id),
      .ack     (ack),
      .pending (pending)
`ifdef CDC_ARB_OVF_EN
      ,
      .ovf     (ovf),
      .ovf_clr (ovf_clr)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clr  = 1'b1;
      req  = '0;
      full = 1'b0;
`ifdef CDC_ARB_OVF_EN
      ovf_clr = 1'b0;
`endif
      tick();
      clr = 1'b0;
   endtask

   task automatic test_reset();
      clr  = 1'b1;
      req  = '0;
      full = 1'b0;
`ifdef CDC_ARB_OVF_EN
      ovf_clr = 1'b0;
`endif
      #2;
      tick();
      compared++;
      if (issue !== 1'b0) begin mismatched++; $display("[TB] FAIL reset.issue got=%b want=0", issue); end
      compared++;
      if (issue_id !== 2'd0) begin mismatched++; $display("[TB] FAIL reset.issue_id got=%0d want=0", issue_id); end
      compared++;
      if (ack !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset.ack got=%b want=0000", ack); end
      compared++;
      if (pending !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset.pending got=%b want=0000", pending); end
`ifdef CDC_ARB_OVF_EN
      compared++;
      if (ovf !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset.ovf got=%b want=0000", ovf); end
`endif
      clr = 1'b0;
   endtask

   task automatic test_single();
      logic [6:0] exp_issue;
      exp_issue = 7'b0001110;
      do_reset();
      for (int c = 0; c < 7; c++) begin
         req = (c < 3) ? 4'b0100 : 4'b0000;
         tick();
         compared++;
         if (issue !== exp_issue[c]) begin
            mismatched++;
            $display("[TB] FAIL single.issue cyc=%0d got=%b want=%b", c, issue, exp_issue[c]);
         end
         if (exp_issue[c]) begin
            compared++;
            if (issue_id !== 2'd2 || ack !== 4'b0100) begin
               mismatched++;
               $display("[TB] FAIL single.id cyc=%0d got id=%0d ack=%b want id=2 ack=0100", c, issue_id, ack);
            end
         end
         if (c == 0) begin
            compared++;
            if (pending !== 4'b0100) begin mismatched++; $display("[TB] FAIL single.pending_hi got=%b want=0100", pending); end
         end
      end
      compared++;
      if (pending !== 4'b0000) begin mismatched++; $display("[TB] FAIL single.pending_lo got=%b want=0000", pending); end
   endtask

   task automatic test_fairness();
      logic [1:0] exp_id;
      do_reset();
      full = 1'b1;
      req  = 4'b1111;
      tick();
      tick();
      req = 4'b0000;
      compared++;
      if (pending !== 4'b1111 || issue !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL fair.preload got pending=%b issue=%b want 1111/0", pending, issue);
      end
      full = 1'b0;
      for (int c = 0; c < 8; c++) begin
         exp_id = 2'(c % 4);
         tick();
         compared++;
         if (issue !== 1'b1 || issue_id !== exp_id || ack !== (4'b0001 << exp_id)) begin
            mismatched++;
            $display("[TB] FAIL fair.seq step=%0d got issue=%b id=%0d ack=%b want 1/%0d", c, issue, issue_id, ack, exp_id);
         end
      end
      tick();
      compared++;
      if (issue !== 1'b0 || pending !== 4'b0000) begin
         mismatched++;
         $display("[TB] FAIL fair.idle got issue=%b pending=%b want 0/0000", issue, pending);
      end
   endtask

   task automatic test_stall();
      do_reset();
      full = 1'b1;
      for (int c = 0; c < 10; c++) begin
         req = (c % 2 == 0) ? 4'b0010 : 4'b0000;
         tick();
         compared++;
         if (issue !== 1'b0) begin mismatched++; $display("[TB] FAIL stall.no_issue cyc=%0d got=%b want=0", c, issue); end
      end
      req = 4'b0000;
      compared++;
      if (pending !== 4'b0010) begin mismatched++; $display("[TB] FAIL stall.pending got=%b want=0010", pending); end
      full = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         compared++;
         if (issue !== (c < 5)) begin
            mismatched++;
            $display("[TB] FAIL stall.drain cyc=%0d got=%b want=%b", c, issue, (c < 5));
         end
         if (c < 5) begin
            compared++;
            if (issue_id !== 2'd1 || ack !== 4'b0010) begin
               mismatched++;
               $display("[TB] FAIL stall.id cyc=%0d got id=%0d ack=%b want 1/0010", c, issue_id, ack);
            end
         end
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      req = 4'b0001;
      tick();
      compared++;
      if (issue !== 1'b0) begin mismatched++; $display("[TB] FAIL simul.first got=%b want=0", issue); end
      req = 4'b0001;
      tick();
      req = 4'b0000;
      compared++;
      if (issue !== 1'b1 || pending !== 4'b0001) begin
         mismatched++;
         $display("[TB] FAIL simul.hold got issue=%b pending=%b want 1/0001", issue, pending);
      end
      tick();
      compared++;
      if (issue !== 1'b1 || issue_id !== 2'd0 || pending !== 4'b0000) begin
         mismatched++;
         $display("[TB] FAIL simul.second got issue=%b id=%0d pending=%b want 1/0/0000", issue, issue_id, pending);
      end
      tick();
      compared++;
      if (issue !== 1'b0) begin mismatched++; $display("[TB] FAIL simul.done got=%b want=0", issue); end
   endtask

   task automatic test_saturation();
      int n_issue;
      do_reset();
      full = 1'b1;
      for (int c = 0; c < 17; c++) begin
         req = 4'b1000;
         tick();
      end
      req = 4'b0000;
      compared++;
      if (pending !== 4'b1000 || issue !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL sat.pending got pending=%b issue=%b want 1000/0", pending, issue);
      end
`ifdef CDC_ARB_OVF_EN
      compared++;
      if (ovf !== 4'b1000) begin mismatched++; $display("[TB] FAIL sat.ovf got=%b want=1000", ovf); end
      req     = 4'b1000;
      ovf_clr = 1'b1;
      tick();
      compared++;
      if (ovf !== 4'b1000) begin mismatched++; $display("[TB] FAIL sat.set_wins got=%b want=1000", ovf); end
      req = 4'b0000;
      tick();
      ovf_clr = 1'b0;
      compared++;
      if (ovf !== 4'b0000) begin mismatched++; $display("[TB] FAIL sat.ovf_clr got=%b want=0000", ovf); end
`endif
      full    = 1'b0;
      n_issue = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (issue) begin
            n_issue++;
            compared++;
            if (issue_id !== 2'd3) begin mismatched++; $display("[TB] FAIL sat.id got=%0d want=3", issue_id); end
         end
      end
      compared++;
      if (n_issue !== 15) begin mismatched++; $display("[TB] FAIL sat.count got=%0d want=15", n_issue); end
   endtask

   task automatic test_async_reset();
      do_reset();
      req = 4'b0011;
      tick();
      tick();
      req = 4'b0000;
      compared++;
      if (issue !== 1'b1) begin mismatched++; $display("[TB] FAIL areset.pre got=%b want=1", issue); end
      #2;
      clr = 1'b1;
      #1;
      compared++;
      if (issue !== 1'b0 || ack !== 4'b0000 || pending !== 4'b0000 || issue_id !== 2'd0) begin
         mismatched++;
         $display("[TB] FAIL areset.immediate got issue=%b ack=%b pending=%b id=%0d want all 0", issue, ack, pending, issue_id);
      end
      tick();
      clr = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         compared++;
         if (issue !== 1'b0) begin mismatched++; $display("[TB] FAIL areset.quiet cyc=%0d got=%b want=0", c, issue); end
      end
      req = 4'b0010;
      tick();
      req = 4'b0000;
      tick();
      compared++;
      if (issue !== 1'b1 || issue_id !== 2'd1) begin
         mismatched++;
         $display("[TB] FAIL areset.new_req got issue=%b id=%0d want 1/1", issue, issue_id);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_stall();
      test_simultaneous();
      test_saturation();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
